program_loader: RTL and testbench

//  Boot-time initiator for the 32 KB program memory write port. Receives a framed byte

---
 rtl/program_loader.sv | 240 ++++++++++++++++++++++++
 tb/tb_program_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: framed LE byte stream -> program memory words, checksum, CPU reset release.
// Optional read-back verification pass is enabled by defining LOADER_READBACK_VERIFY_EN.
module program_loader #(
    parameter logic [29:0] BASE_WORD_ADDR = 30'd0,
    parameter int unsigned MAX_WORDS      = 8192,
    parameter logic [31:0] MAGIC          = 32'h52495343,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [29:0] mem_address_o,
    output logic        mem_wen_o,
    output logic        mem_ren_o,
    output logic [31:0] mem_data_in_o,
    output logic [3:0]  mem_byte_select_vector_o,
    input  logic [31:0] mem_data_out_i,
    output logic        cpu_reset_hold_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [2:0]  error_code_o,
    output logic [13:0] words_loaded_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_MAGIC, S_LEN, S_DATA, S_CSUM, S_VERIFY, S_DONE, S_ERROR
    } state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] MAX_W        = 32'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [13:0] len_q, len_d;
    logic [13:0] words_q, words_d;
    logic [31:0] sum_q, sum_d;
    logic [31:0] idle_q, idle_d;
    logic [2:0]  err_code_q, err_code_d;
    logic        wen_q, wen_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        receiving;
    logic        accept;
    logic [31:0] word;

    assign receiving = (state_q == S_MAGIC) || (state_q == S_LEN) ||
                       (state_q == S_DATA)  || (state_q == S_CSUM);
    assign accept    = receiving && rx_valid_i;
    // Bytes arrive LSB first, so each new byte enters at the top of the shifter.
    assign word      = {rx_data_i, shift_q[31:8]};

`ifdef LOADER_READBACK_VERIFY_EN
    logic [14:0] vcnt_q, vcnt_d;
    logic [31:0] vsum_q, vsum_d;
    logic [31:0] csum_q, csum_d;
    logic        ren_q, ren_d;
`else
    logic        unused_rdata;
    assign unused_rdata = ^mem_data_out_i;
`endif

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        len_d      = len_q;
        words_d    = words_q;
        sum_d      = sum_q;
        idle_d     = idle_q;
        err_code_d = err_code_q;
        wen_d      = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef LOADER_READBACK_VERIFY_EN
        vcnt_d     = vcnt_q;
        vsum_d     = vsum_q;
        csum_d     = csum_q;
        ren_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) begin
                    state_d    = S_MAGIC;
                    err_code_d = 3'd0;
                    words_d    = 14'd0;
                    sum_d      = 32'd0;
                    byte_cnt_d = 2'd0;
                    idle_d     = 32'd0;
                end
            end
            S_MAGIC, S_LEN, S_DATA, S_CSUM: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = word;
                    idle_d     = 32'd0;
                    if (byte_cnt_q == 2'd3) begin
                        case (state_q)
                            S_MAGIC: begin
                                if (word != MAGIC) begin
                                    state_d    = S_ERROR;
                                    err_code_d = 3'd1;
                                end else begin
                                    state_d = S_LEN;
                                end
                            end
                            S_LEN: begin
                                if (word == 32'd0 || word > MAX_W) begin
                                    state_d    = S_ERROR;
                                    err_code_d = 3'd2;
                                end else begin
                                    len_d   = word[13:0];
                                    state_d = S_DATA;
                                end
                            end
                            S_DATA: begin
                                wen_d   = 1'b1;
                                addr_d  = BASE_WORD_ADDR + {16'd0, words_q};
                                wdata_d = word;
                                words_d = words_q + 14'd1;
                                sum_d   = sum_q + word;
                                if (words_q + 14'd1 == len_q) begin
                                    state_d = S_CSUM;
                                end
                            end
                            default: begin
                                if (word != sum_q) begin
                                    state_d    = S_ERROR;
                                    err_code_d = 3'd3;
                                end else begin
`ifdef LOADER_READBACK_VERIFY_EN
                                    state_d = S_VERIFY;
                                    vcnt_d  = 15'd0;
                                    vsum_d  = 32'd0;
                                    csum_d  = word;
`else
                                    state_d = S_DONE;
`endif
                                end
                            end
                        endcase
                    end
                end else if (idle_q == TIMEOUT_LAST) begin
                    state_d    = S_ERROR;
                    err_code_d = 3'd4;
                end else begin
                    idle_d = idle_q + 32'd1;
                end
            end
`ifdef LOADER_READBACK_VERIFY_EN
            S_VERIFY: begin
                // Reads issue at vcnt 0..N-1, appear on the port one cycle later
                // and return data one cycle after that.
                vcnt_d = vcnt_q + 15'd1;
                if (vcnt_q < {1'b0, len_q}) begin
                    ren_d  = 1'b1;
                    addr_d = BASE_WORD_ADDR + {15'd0, vcnt_q};
                end
                if (vcnt_q >= 15'd2 && vcnt_q <= {1'b0, len_q} + 15'd1) begin
                    vsum_d = vsum_q + mem_data_out_i;
                end
                if (vcnt_q == {1'b0, len_q} + 15'd2) begin
                    if (vsum_q == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_ERROR;
                        err_code_d = 3'd5;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            shift_q    <= 32'd0;
            len_q      <= 14'd0;
            words_q    <= 14'd0;
            sum_q      <= 32'd0;
            idle_q     <= 32'd0;
            err_code_q <= 3'd0;
            wen_q      <= 1'b0;
            addr_q     <= 30'd0;
            wdata_q    <= 32'd0;
`ifdef LOADER_READBACK_VERIFY_EN
            vcnt_q     <= 15'd0;
            vsum_q     <= 32'd0;
            csum_q     <= 32'd0;
            ren_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            words_q    <= words_d;
            sum_q      <= sum_d;
            idle_q     <= idle_d;
            err_code_q <= err_code_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifdef LOADER_READBACK_VERIFY_EN
            vcnt_q     <= vcnt_d;
            vsum_q     <= vsum_d;
            csum_q     <= csum_d;
            ren_q      <= ren_d;
`endif
        end
    end

    assign rx_ready_o               = receiving;
    assign mem_address_o            = addr_q;
    assign mem_wen_o                = wen_q;
`ifdef LOADER_READBACK_VERIFY_EN
    assign mem_ren_o                = ren_q;
`else
    assign mem_ren_o                = 1'b0;
`endif
    assign mem_data_in_o            = wdata_q;
    assign mem_byte_select_vector_o = {4{wen_q}};
    assign cpu_reset_hold_o         = (state_q != S_DONE);
    assign busy_o                   = receiving || (state_q == S_VERIFY);
    assign done_o                   = (state_q == S_DONE);
    assign error_o                  = (state_q == S_ERROR);
    assign error_code_o             = err_code_q;
    assign words_loaded_o           = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized frame stimulus with a write scoreboard checked by an independent monitor.
module tb_program_loader;

    localparam int          TMO    = 100;
    localparam int          MAXW   = 8192;
    localparam logic [31:0] MAGIC_W = 32'h52495343;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [29:0] mem_address;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_data_in;
    logic [3:0]  mem_bsel;
    logic [31:0] mem_data_out;
    logic        cpu_hold;
    logic        busy, done, error;
    logic [2:0]  error_code;
    logic [13:0] words_loaded;

    always #5 clk = ~clk;

    program_loader #(
        .BASE_WORD_ADDR (30'd0),
        .MAX_WORDS      (MAXW),
        .MAGIC          (MAGIC_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i                    (clk),
        .reset_i                  (reset),
        .start_i                  (start),
        .rx_data_i                (rx_data),
        .rx_valid_i               (rx_valid),
        .rx_ready_o               (rx_ready),
        .mem_address_o            (mem_address),
        .mem_wen_o                (mem_wen),
        .mem_ren_o                (mem_ren),
        .mem_data_in_o            (mem_data_in),
        .mem_byte_select_vector_o (mem_bsel),
        .mem_data_out_i           (mem_data_out),
        .cpu_reset_hold_o         (cpu_hold),
        .busy_o                   (busy),
        .done_o                   (done),
        .error_o                  (error),
        .error_code_o             (error_code),
        .words_loaded_o           (words_loaded)
    );

    // Program memory model: one-cycle read latency, optional injected bit flip on reads.
    logic [31:0] mem_model [0:8191];
    logic        flip_en = 1'b0;
    always @(posedge clk) begin
        if (mem_wen) mem_model[mem_address[12:0]] <= mem_data_in;
        if (mem_ren) mem_data_out <= mem_model[mem_address[12:0]] ^ (flip_en ? 32'h0000_0100 : 32'h0);
    end

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    int total  = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (!reset && mem_wen) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", mem_address, mem_data_in);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(mem_address), 64'(e.a));
                chk("wr_data", 64'(mem_data_in), 64'(e.d));
                chk("wr_bsel", 64'(mem_bsel), 64'hF);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n_idle;
        int t;
        n_idle = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
        for (int i = 0; i < n_idle; i++) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) chk("rx_ready", 64'(rx_ready), 64'd1);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("hold_after_start", 64'(cpu_hold), 64'd1);
    endtask

    task automatic wait_end();
        int t = 0;
        rx_valid = 1'b0;
        while (!(done || error) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("end_reached", 64'(done | error), 64'd1);
    endtask

    task automatic check_status(input string tag, input int code, input int nwords);
        chk({tag, "_error"},      64'(error),        64'(code != 0));
        chk({tag, "_done"},       64'(done),         64'(code == 0));
        chk({tag, "_code"},       64'(error_code),   64'(code));
        chk({tag, "_hold"},       64'(cpu_hold),     64'(code != 0));
        chk({tag, "_busy"},       64'(busy),         64'd0);
        chk({tag, "_words"},      64'(words_loaded), 64'(nwords));
        chk({tag, "_writes_all"}, 64'(exp_q.size()), 64'd0);
        $display("frame %s: code=%0d words=%0d done=%0b error=%0b", tag, error_code, words_loaded, done, error);
    endtask

    // Reference model: the outcome follows from the frame contents alone.
    task automatic frame(input string tag, input logic [31:0] magic, input logic [31:0] n,
                         input logic [31:0] payload[$], input logic [31:0] csum_delta,
                         input int gap, input bit flip);
        logic [31:0] sum = 32'd0;
        int code;
        int nwords = 0;
        pulse_start();
        if (magic != MAGIC_W) begin
            code = 1;
            send_word(magic, gap);
        end else if (n == 32'd0 || n > 32'(MAXW)) begin
            code = 2;
            send_word(magic, gap);
            send_word(n, gap);
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                sum += payload[i];
                exp_q.push_back('{a: 30'(i), d: payload[i]});
            end
            nwords = int'(n);
            code = (csum_delta != 32'd0) ? 3 : (flip ? 5 : 0);
            send_word(magic, gap);
            send_word(n, gap);
            for (int i = 0; i < int'(n); i++) send_word(payload[i], gap);
            send_word(sum + csum_delta, gap);
        end
        flip_en = flip;
        wait_end();
        check_status(tag, code, nwords);
        flip_en = 1'b0;
    endtask

    function automatic void rand_payload(input int n, output logic [31:0] q[$]);
        q = {};
        for (int i = 0; i < n; i++) q.push_back($urandom);
    endfunction

    initial begin
        logic [31:0] pl[$];
        int t;
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_hold",  64'(cpu_hold),     64'd1);
        chk("rst_busy",  64'(busy),         64'd0);
        chk("rst_done",  64'(done),         64'd0);
        chk("rst_ready", 64'(rx_ready),     64'd0);
        chk("rst_words", 64'(words_loaded), 64'd0);
        reset = 1'b0;

        pl = '{32'h11223344, 32'hAABBCCDD};
        frame("basic", MAGIC_W, 32'd2, pl, 32'd0, 0, 1'b0);
        frame("bad_magic", 32'hDEADBEEF, 32'd2, pl, 32'd0, 1, 1'b0);
        frame("len_zero", MAGIC_W, 32'd0, pl, 32'd0, 1, 1'b0);
        frame("len_big", MAGIC_W, 32'd8193, pl, 32'd0, 1, 1'b0);
        rand_payload(5, pl);
        frame("bad_csum", MAGIC_W, 32'd5, pl, 32'd1, 2, 1'b0);

        // Stall mid-DATA long enough to trip the inter-byte timeout.
        pulse_start();
        send_word(MAGIC_W, 0);
        send_word(32'd3, 0);
        exp_q.push_back('{a: 30'd0, d: 32'hCAFEF00D});
        send_word(32'hCAFEF00D, 0);
        send_byte(8'h5A, 0);
        wait_end();
        check_status("timeout", 4, 1);

        rand_payload(6, pl);
        frame("rearm", MAGIC_W, 32'd6, pl, 32'd0, 3, 1'b0);
        for (int k = 0; k < 6; k++) begin
            int n = int'($urandom_range(20, 1));
            rand_payload(n, pl);
            frame("random", MAGIC_W, 32'(n), pl, ($urandom_range(3, 0) == 0) ? 32'($urandom_range(255, 1)) : 32'd0, 3, 1'b0);
        end

        // Back-to-back stream of a large frame, aborted by reset at word 100.
        pulse_start();
        send_word(MAGIC_W, 0);
        send_word(32'd4096, 0);
        for (int i = 0; i < 100; i++) begin
            logic [31:0] r = $urandom;
            exp_q.push_back('{a: 30'(i), d: r});
            send_word(r, 0);
        end
        #1 reset = 1'b1;
        #1;
        rx_valid = 1'b0;
        chk("abort_hold",  64'(cpu_hold),     64'd1);
        chk("abort_busy",  64'(busy),         64'd0);
        chk("abort_err",   64'(error),        64'd0);
        chk("abort_ready", 64'(rx_ready),     64'd0);
        chk("abort_wen",   64'(mem_wen),      64'd0);
        chk("abort_addr",  64'(mem_address),  64'd0);
        chk("abort_data",  64'(mem_data_in),  64'd0);
        chk("abort_words", 64'(words_loaded), 64'd0);
        chk("abort_code",  64'(error_code),   64'd0);
        chk("abort_sb",    64'(exp_q.size()), 64'd0);
        $display("frame abort: reset at word 100");
        @(negedge clk);
        reset = 1'b0;
        rand_payload(8, pl);
        frame("post_reset", MAGIC_W, 32'd8, pl, 32'd0, 1, 1'b0);

`ifdef LOADER_READBACK_VERIFY_EN
        rand_payload(7, pl);
        frame("verify_flip", MAGIC_W, 32'd7, pl, 32'd0, 1, 1'b1);
`endif
        t = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

endmodule
